// File: rtl/emu_time_pkg.sv
// Shared types and constants for the emulation time scheduler.
package emu_time_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2,
    HALT   = 2'd3
  } sched_state_e;

  // All-ones value of width w (w <= 64); reserved as "no clock pending".
  function automatic logic [63:0] sentinel_of(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/time_min_tree.sv
// Masked unsigned minimum over the gated clock times plus the mask of clocks at that minimum.
module time_min_tree
  import emu_time_pkg::*;
#(
  parameter int N_CLK      = 2,
  parameter int TIME_WIDTH = 32
) (
  input  logic [N_CLK*TIME_WIDTH-1:0] times,
  input  logic [N_CLK-1:0]            active,
  output logic [TIME_WIDTH-1:0]       min_time,
  output logic [N_CLK-1:0]            min_mask
);

  localparam logic [TIME_WIDTH-1:0] SENTINEL = TIME_WIDTH'(sentinel_of(TIME_WIDTH));

  always_comb begin
    min_time = SENTINEL;
    for (int k = 0; k < N_CLK; k++)
      if (active[k] && (times[k*TIME_WIDTH +: TIME_WIDTH] < min_time))
        min_time = times[k*TIME_WIDTH +: TIME_WIDTH];
    // No active clock means nothing is due, so nothing may be flagged.
    min_mask = '0;
    for (int k = 0; k < N_CLK; k++)
      min_mask[k] = active[k] && (min_time != SENTINEL) &&
                    (times[k*TIME_WIDTH +: TIME_WIDTH] == min_time);
  end

endmodule

// File: rtl/emu_time_sched.sv
// Event scheduler: issues the earliest gated-clock edge time, one event per ISSUE/SETTLE/SETTLE period.
module emu_time_sched
  import emu_time_pkg::*;
#(
  parameter int N_CLK      = 2,
  parameter int TIME_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                        clk_sys,
  input  logic                        rst_n,
  input  logic [N_CLK*TIME_WIDTH-1:0] time_clocks,
  input  logic [N_CLK-1:0]            clk_active,
  input  logic                        run,
  input  logic                        step_req,
  input  logic [TIME_WIDTH-1:0]       stop_time,
  output logic [TIME_WIDTH-1:0]       time_next,
  output logic [N_CLK-1:0]            fire_mask,
  output logic                        step_ack,
  output logic                        halted,
  output logic [TIME_WIDTH-1:0]       emu_time,
  output logic [CNT_WIDTH-1:0]        event_cnt
);

  localparam logic [TIME_WIDTH-1:0] SENTINEL = TIME_WIDTH'(sentinel_of(TIME_WIDTH));

  sched_state_e          state, state_nx, launch_st;
  logic [TIME_WIDTH-1:0] min_c, min_r;
  logic [N_CLK-1:0]      mask_c, min_mask_r;
  logic                  settle_cnt, pending, step_new, set_pend, clr_pend;

  time_min_tree #(.N_CLK(N_CLK), .TIME_WIDTH(TIME_WIDTH)) u_min (
    .times    (time_clocks),
    .active   (clk_active),
    .min_time (min_c),
    .min_mask (mask_c)
  );

  // A step_req still high in its own ack cycle is the old request, not a new one.
  assign step_new = step_req && !pending && !step_ack;

  always_comb begin
    launch_st = ISSUE;
    if (min_r == SENTINEL)       launch_st = IDLE;
    else if (min_r >= stop_time) launch_st = HALT;
  end

  always_comb begin
    state_nx = state;
    set_pend = 1'b0;
    clr_pend = 1'b0;
    case (state)
      IDLE:
        if (run || step_new) begin
          state_nx = launch_st;
          set_pend = step_new && (launch_st == ISSUE);
        end
      ISSUE:
        state_nx = SETTLE;
      SETTLE:
        if (settle_cnt) begin
          if (pending) begin
            clr_pend = 1'b1;
            state_nx = IDLE;
          end else if (run) begin
            state_nx = launch_st;
            set_pend = step_new && (launch_st == ISSUE);
          end else begin
            state_nx = IDLE;
          end
        end
      HALT:
        if (!run && !step_req) state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= 1'b0;
      pending    <= 1'b0;
      step_ack   <= 1'b0;
      min_r      <= SENTINEL;
      min_mask_r <= '0;
      time_next  <= SENTINEL;
      fire_mask  <= '0;
      emu_time   <= '0;
      event_cnt  <= '0;
    end else begin
      state      <= state_nx;
      settle_cnt <= (state == SETTLE) ? ~settle_cnt : 1'b0;
      min_r      <= min_c;
      min_mask_r <= mask_c;
      step_ack   <= clr_pend;
      if (set_pend)      pending <= 1'b1;
      else if (clr_pend) pending <= 1'b0;
      // Broadcast is loaded on entry so it is valid exactly during the ISSUE cycle.
      if (state_nx == ISSUE) begin
        time_next <= min_r;
        fire_mask <= min_mask_r;
        emu_time  <= min_r;
        event_cnt <= event_cnt + CNT_WIDTH'(1);
      end else begin
        time_next <= SENTINEL;
        fire_mask <= '0;
      end
    end
  end

  assign halted = (state == HALT);

endmodule

// File: tb/tb_emu_time_sched.sv
// Randomized bench for emu_time_sched against an event-list model of the clock schedule.
module tb_emu_time_sched;

  localparam int N  = 2;
  localparam int TW = 32;
  localparam int CW = 32;
  localparam logic [TW-1:0] SENT = '1;

  logic              clk_sys = 1'b0;
  logic              rst_n   = 1'b1;
  logic [N*TW-1:0]   time_clocks = '0;
  logic [N-1:0]      clk_active  = '0;
  logic              run = 1'b0, step_req = 1'b0;
  logic [TW-1:0]     stop_time = '0;
  logic [TW-1:0]     time_next, emu_time;
  logic [N-1:0]      fire_mask;
  logic              step_ack, halted;
  logic [CW-1:0]     event_cnt;

  int n_vec = 0, n_err = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic [TW-1:0] cur [N];
  logic [TW-1:0] per [N];
  logic [N-1:0]  act;
  logic [TW-1:0] stop;

  emu_time_sched #(.N_CLK(N), .TIME_WIDTH(TW), .CNT_WIDTH(CW)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .time_clocks(time_clocks), .clk_active(clk_active),
    .run(run), .step_req(step_req), .stop_time(stop_time), .time_next(time_next),
    .fire_mask(fire_mask), .step_ack(step_ack), .halted(halted), .emu_time(emu_time),
    .event_cnt(event_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic drive_times();
    for (int k = 0; k < N; k++) time_clocks[k*TW +: TW] = cur[k];
    clk_active = act;
    stop_time  = stop;
  endtask

  task automatic set_clk(input int a, input int b, input int pa, input int pb,
                         input logic [N-1:0] ac, input int st);
    cur[0] = TW'(a);  cur[1] = TW'(b);
    per[0] = TW'(pa); per[1] = TW'(pb);
    act = ac; stop = TW'(st);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    n_vec++;
    if (time_next !== SENT || fire_mask !== '0 || step_ack !== 1'b0 || halted !== 1'b0 ||
        emu_time !== '0 || event_cnt !== '0) begin
      n_err++;
      $display("FAIL reset: time_next=%h fire=%b ack=%b halted=%b emu=%0d cnt=%0d, required %h 0 0 0 0 0",
               time_next, fire_mask, step_ack, halted, emu_time, event_cnt, SENT);
    end
    rst_n = 1'b1;
    exp_cnt = '0;
    @(negedge clk_sys);
  endtask

  // Free-running scenario: the model lists every event (time, firing set) until a halt.
  task automatic run_scenario(input string tag);
    logic [TW-1:0] exp_t[$];
    logic [N-1:0]  exp_m[$];
    logic [TW-1:0] mt [N];
    logic [TW-1:0] m;
    logic [N-1:0]  mk;
    bit            exp_halt;
    int            n_iss, last_c, budget;
    exp_halt = 0;
    for (int k = 0; k < N; k++) mt[k] = cur[k];
    if (act != '0) begin
      for (int e = 0; e < 200; e++) begin
        m = SENT;
        for (int k = 0; k < N; k++) if (act[k] && mt[k] < m) m = mt[k];
        if (m >= stop) begin exp_halt = 1; break; end
        mk = '0;
        for (int k = 0; k < N; k++)
          if (act[k] && mt[k] == m) begin mk[k] = 1'b1; mt[k] = mt[k] + per[k]; end
        exp_t.push_back(m);
        exp_m.push_back(mk);
      end
    end

    run = 1'b0;
    drive_times();
    repeat (2) @(negedge clk_sys);
    run = 1'b1;
    n_iss = 0; last_c = 0;
    budget = 3 * exp_t.size() + 20;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk_sys);
      if (time_next !== SENT) begin
        n_vec++;
        if (n_iss >= exp_t.size()) begin
          n_err++;
          $display("FAIL %s extra_issue: time_next=%0d, required no event", tag, time_next);
        end else begin
          if (time_next !== exp_t[n_iss] || fire_mask !== exp_m[n_iss]) begin
            n_err++;
            $display("FAIL %s event%0d: time_next=%0d fire=%b, required %0d %b",
                     tag, n_iss, time_next, fire_mask, exp_t[n_iss], exp_m[n_iss]);
          end
          exp_cnt = exp_cnt + 1;
          n_vec++;
          if (event_cnt !== exp_cnt || emu_time !== exp_t[n_iss]) begin
            n_err++;
            $display("FAIL %s count%0d: event_cnt=%0d emu_time=%0d, required %0d %0d",
                     tag, n_iss, event_cnt, emu_time, exp_cnt, exp_t[n_iss]);
          end
          if (n_iss > 0) begin
            n_vec++;
            if (c - last_c != 3) begin
              n_err++;
              $display("FAIL %s period%0d: gap=%0d, required 3", tag, n_iss, c - last_c);
            end
          end
          for (int k = 0; k < N; k++) if (exp_m[n_iss][k]) cur[k] = cur[k] + per[k];
          drive_times();
        end
        last_c = c;
        n_iss++;
      end
      if (halted) break;
    end
    n_vec++;
    if (n_iss != exp_t.size()) begin
      n_err++;
      $display("FAIL %s num_events: got %0d, required %0d", tag, n_iss, exp_t.size());
    end
    n_vec++;
    if (halted !== exp_halt || event_cnt !== exp_cnt) begin
      n_err++;
      $display("FAIL %s end_state: halted=%b cnt=%0d, required %b %0d",
               tag, halted, event_cnt, exp_halt, exp_cnt);
    end
    run = 1'b0;
    repeat (2) @(negedge clk_sys);
    n_vec++;
    if (halted !== 1'b0 || time_next !== SENT) begin
      n_err++;
      $display("FAIL %s release: halted=%b time_next=%h, required 0 %h", tag, halted, time_next, SENT);
    end
  endtask

  task automatic test_step();
    int iss_c, ack_c, n_iss, n_ack;
    set_clk(5, 7, 10, 10, 2'b11, 100);
    run = 1'b0;
    drive_times();
    repeat (2) @(negedge clk_sys);
    step_req = 1'b1;
    iss_c = -100; ack_c = -1; n_iss = 0; n_ack = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_sys);
      if (time_next !== SENT) begin
        n_iss++; iss_c = c;
        exp_cnt = exp_cnt + 1;
        n_vec++;
        if (time_next !== TW'(5) || fire_mask !== 2'b01 || event_cnt !== exp_cnt) begin
          n_err++;
          $display("FAIL step_issue: time_next=%0d fire=%b cnt=%0d, required 5 01 %0d",
                   time_next, fire_mask, event_cnt, exp_cnt);
        end
        cur[0] = cur[0] + per[0];
        drive_times();
      end
      if (step_ack) begin n_ack++; ack_c = c; step_req = 1'b0; end
    end
    step_req = 1'b0;
    n_vec++;
    if (n_iss != 1 || n_ack != 1) begin
      n_err++;
      $display("FAIL step_count: issues=%0d acks=%0d, required 1 1", n_iss, n_ack);
    end
    n_vec++;
    if (ack_c - iss_c != 3) begin
      n_err++;
      $display("FAIL step_ack_latency: got %0d cycles, required 3", ack_c - iss_c);
    end
  endtask

  task automatic test_reset_mid_settle();
    bit seen;
    set_clk(10, 15, 10, 10, 2'b11, 100);
    run = 1'b0;
    drive_times();
    repeat (2) @(negedge clk_sys);
    step_req = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk_sys);
      if (time_next !== SENT) seen = 1;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL rst_mid_issue: no ISSUE within 10 cycles, required one");
    end
    @(negedge clk_sys);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (time_next !== SENT || fire_mask !== '0 || step_ack !== 1'b0 || halted !== 1'b0 ||
        emu_time !== '0 || event_cnt !== '0) begin
      n_err++;
      $display("FAIL rst_mid_settle: time_next=%h fire=%b ack=%b halted=%b emu=%0d cnt=%0d, required reset values",
               time_next, fire_mask, step_ack, halted, emu_time, event_cnt);
    end
    exp_cnt = '0;
    step_req = 1'b0;
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_sys);
      n_vec++;
      if (step_ack !== 1'b0 || time_next !== SENT) begin
        n_err++;
        $display("FAIL rst_no_ack: ack=%b time_next=%h, required 0 %h", step_ack, time_next, SENT);
      end
    end
  endtask

  initial begin
    test_reset();
    set_clk(10, 15, 10, 10, 2'b11, 100); run_scenario("basic");
    set_clk(20, 20, 7, 9, 2'b11, 40);    run_scenario("tie");
    set_clk(0, 0, 10, 10, 2'b11, 30);    run_scenario("stop");
    set_clk(3, 4, 5, 5, 2'b00, 100);     run_scenario("inactive");
    test_step();
    for (int r = 0; r < 6; r++) begin
      set_clk($urandom_range(0, 50), $urandom_range(0, 50), $urandom_range(5, 20),
              $urandom_range(5, 20), 2'($urandom_range(1, 3)), $urandom_range(20, 120));
      run_scenario($sformatf("rand%0d", r));
    end
    test_reset_mid_settle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/emu_time_sched.md
EMU_TIME_SCHED -- requirements
Module: emu_time_sched

Interface
REQ-001 Parameter N_CLK, default 2: number of gated clocks scheduled; legal range 1..8.
REQ-002 Parameter TIME_WIDTH, default 32: width of every time value.
REQ-003 Parameter CNT_WIDTH, default 32: width of the event counter.
REQ-004 The block SHALL use one clock and one reset: reset is asynchronous and active-low.
REQ-005 clk_sys  input  1  system clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 time_clocks  input  N_CLK*TIME_WIDTH  next edge time of each gated clock; clock k occupies slice [k*TIME_WIDTH +: TIME_WIDTH].
REQ-008 clk_active  input  N_CLK  per-clock participation mask; 0 excludes that clock from scheduling.
REQ-009 run  input  1  level; 1 = free-running event issue.
REQ-010 step_req  input  1  single-event request; held until step_ack.
REQ-011 stop_time  input  TIME_WIDTH  halt threshold.
REQ-012 time_next  output  TIME_WIDTH  registered broadcast time to all gated clocks.
REQ-013 fire_mask  output  N_CLK  registered; bit k = clock k fires this cycle.
REQ-014 step_ack  output  1  one-cycle pulse completing a step.
REQ-015 halted  output  1  stop_time reached.
REQ-016 emu_time  output  TIME_WIDTH  time of the last issued event.
REQ-017 event_cnt  output  CNT_WIDTH  number of issued events, wraps modulo 2^CNT_WIDTH.

Function
REQ-018 SENTINEL = all-ones TIME_WIDTH; reserved, never a legal clock time; time_next SHALL equal SENTINEL in every non-ISSUE cycle.
REQ-019 min_r SHALL be registered every cycle as the unsigned minimum of time_clocks over bits with clk_active=1; SENTINEL if none active; 1-cycle latency.
REQ-020 min_mask_r SHALL be registered alongside min_r: bit k = active and time_clocks[k]==min.
REQ-021 States: IDLE, ISSUE, SETTLE, HALT; reset state IDLE.
REQ-022 IDLE -> ISSUE when run=1, or when step_req=1 and no step pending; the step is latched as pending.
REQ-023 IDLE -> HALT instead of ISSUE if min_r >= stop_time (unsigned); no event issued.
REQ-024 If min_r == SENTINEL, the block SHALL remain in IDLE and issue nothing.
REQ-025 ISSUE lasts exactly 1 cycle: time_next=min_r, fire_mask=min_mask_r, emu_time<=min_r, event_cnt+1.
REQ-026 Ties: all clocks equal to min fire in the same ISSUE cycle; one event counted.
REQ-027 SETTLE lasts exactly 2 cycles (pipeline refill after clock time update); event period in run mode = 3 cycles.
REQ-028 SETTLE exit: if a step is pending, pulse step_ack, clear pending, -> IDLE; else if run=1 -> ISSUE (subject to REQ-023/024 checks, else IDLE/HALT); else -> IDLE.
REQ-029 run deasserted during ISSUE/SETTLE: the current event completes, then IDLE.
REQ-030 HALT: halted=1, no events; exits to IDLE only when run=0 and step_req=0.
REQ-031 step_req while run=1: serviced as the next event, acked, then run continues.
REQ-032 clk_active changes take effect via min_r (1-cycle latency); never mid-ISSUE.

Reset
REQ-033 On rst_n=0: state IDLE, time_next=SENTINEL, fire_mask=0, step_ack=0, halted=0, emu_time=0, event_cnt=0, min_r=SENTINEL, min_mask_r=0, pending=0.
REQ-034 Reset asserted mid-ISSUE/SETTLE SHALL abort immediately; no partial ack.

Structure
REQ-035 Shared package emu_time_pkg SHALL hold the state enum and SENTINEL function of TIME_WIDTH.
REQ-036 One sub-module, time_min_tree (combinational masked minimum plus equality mask), SHALL be instantiated once.

Verification
REQ-037 N_CLK=2, times {10,15}, run=1, stop_time=100 -> time_next=10 with fire_mask=01, SENTINEL for 2 cycles, then next min; event_cnt increments every 3 cycles.
REQ-038 Tie: times {20,20} -> single ISSUE with fire_mask=11, event_cnt+1.
REQ-039 run=0, step_req high, times {5,7} -> exactly one ISSUE at 5, step_ack 3 cycles after ISSUE start, back to IDLE.
REQ-040 stop_time=30, clocks advancing by 10 from 0 -> events at 0,10,20; halted=1 when min reaches 30; no ISSUE at 30.
REQ-041 clk_active=00 with run=1 -> no ISSUE, time_next stays SENTINEL, event_cnt unchanged.
REQ-042 rst_n pulsed low during SETTLE -> all outputs at reset values that same cycle, no step_ack.
